tinsel_acc_msg_forwarder: RTL and testbench
===========================================

// Module: tinsel_acc_msg_forwarder
// PURPOSE
//  Parametrised, message-aware successor to the single-flit forwarding accelerator. Sits on a mailbox-mesh
//  accelerator port. Consumes multi-flit messages through an input FIFO and takes the destination from the
//  head flit's payload. Re-addresses every flit of the message to that destination and emits it through an
//  output FIFO. Drops self-addressed messages; idle tokens pass through transparently.
// PARAMETERS
//  TILE_X    0  compile-time NoC tile X of this accelerator
//  TILE_Y    0  compile-time NoC tile Y of this accelerator
//  IN_DEPTH  4  input FIFO entries (power of 2, >=2)
//  OUT_DEPTH 4  output FIFO entries (power of 2, >=2)
//  DROP_SELF 1  1: discard messages whose head dest equals own address; 0: forward them
//  CNT_W     32 statistics counter width (used only with TINSEL_ACC_FWD_STATS_EN)
// PORTS
//  clk        in  1       clock; all state updates on negedge(clk)
//  rst_n      in  1       asynchronous, active-high reset (name kept for BSV interface compatibility)
//  board_x    in  MeshXBits  this board's mesh X
//  board_y    in  MeshYBits  this board's mesh Y
//  in_data    in  $bits(Flit)  incoming flit
//  in_valid   in  1       incoming flit valid
//  in_ready   out 1       = !inFifoFull
//  out_data   out $bits(Flit)  outgoing flit (head of output FIFO)
//  out_valid  out 1       = !outFifoEmpty
//  out_ready  in  1       downstream accepts
//  msg_count, flit_count, drop_count  out CNT_W  only with TINSEL_ACC_FWD_STATS_EN
// BEHAVIOUR
//  Reset (async, rst_n=1): FIFOs emptied, state=HEAD, latched dest=0, counters=0.
//   Reset outputs: in_ready=0 while rst_n=1, then 1; out_valid=0; out_data=0.
//  Handshakes: in transfer when in_valid&&in_ready at negedge; out transfer when out_valid&&out_ready.
//   Push and pop on the same FIFO in the same cycle are legal at any occupancy, including full and empty.
//  Process stage: fires when inFifo non-empty && (outFifo not full || flit is being dropped). Pops inFifo.
//   Pushes at most one flit per cycle to outFifo.
//   Latency: flit accepted at edge k -> out_valid by edge k+1 if outFifo has space.
//   Full throughput: 1 flit/cycle with no backpressure.
//  FSM:
//   HEAD:
//    idle-token flit -> forwarded verbatim; state stays HEAD.
//    else dest := payload[$bits(NetAddr)-1:0].
//    self = DROP_SELF && dest.acc && dest.boardX==board_x && dest.boardY==board_y
//     && dest.tileX==TILE_X && dest.tileY==TILE_Y.
//    self -> flit discarded; notFinalFlit ? DROP : HEAD.
//    else -> out {dest, payload, notFinalFlit, isIdleToken=0}; notFinalFlit ? BODY : HEAD.
//   BODY:
//    each flit -> out {latched dest, payload, notFinalFlit, 0}.
//    Idle tokens in BODY are forwarded verbatim and do not change state.
//    Leaves to HEAD on flit with notFinalFlit=0.
//   DROP: consumes and discards flits until notFinalFlit=0, then HEAD. Does not need outFifo space.
//  Payload is passed unmodified; dest extraction is truncation of low payload bits.
//  Reset mid-message: in-flight flits lost, FSM returns to HEAD.
// CONFIGURATION
//  TINSEL_ACC_FWD_STATS_EN defined:
//   msg_count += 1 per forwarded final flit; flit_count += 1 per forwarded flit.
//   drop_count += 1 per dropped message (on its final flit).
//   Counters wrap modulo 2^CNT_W; idle tokens are not counted.
//  Undefined: counter ports and logic are absent; behaviour otherwise identical.
// STRUCTURE
//  tinsel_acc_pkg: NetAddr and Flit typedefs, FSM state enum, self-address compare function.
//  Sub-module tinsel_acc_flit_fifo: parameterised depth, show-ahead, async active-high reset.
//   Instantiated twice, for inFifo and outFifo.
// TESTING
//  T1 1-flit msg, payload low bits = dest D, out_ready=1 -> one out flit, dest=D, notFinal=0.
//   out_valid on 2nd edge after acceptance.
//  T2 3-flit msg, head payload dest D, body payloads 0xAA/0xBB -> 3 out flits, all dest=D.
//   notFinal = 1,1,0; payloads preserved.
//  T3 DROP_SELF=1, head dest = own acc/board/tile, 2 flits -> no output; drop_count=1.
//   A following msg to D' is forwarded.
//  T4 out_ready=0, stream 16 flits -> in_ready falls after OUT_DEPTH+IN_DEPTH accepts; no loss.
//   Release -> all 16 in order at 1 flit/cycle.
//  T5 idle token between body flits of a msg -> token out verbatim; remaining body flits keep dest D.
//  T6 assert rst_n mid-BODY -> out_valid=0 immediately; new 1-flit msg forwarded with its own head dest.

Source files
------------

// File: rtl/tinsel_acc_pkg.sv
// Shared types for the message-aware forwarding accelerator: mesh address,
// flit layout, forwarder FSM state and the own-address compare.
package tinsel_acc_pkg;

  localparam int MESH_X_BITS  = 2;
  localparam int MESH_Y_BITS  = 2;
  localparam int TILE_X_BITS  = 2;
  localparam int TILE_Y_BITS  = 2;
  localparam int LOCAL_BITS   = 6;
  localparam int PAYLOAD_BITS = 32;

  typedef struct packed {
    logic                   acc;
    logic [MESH_Y_BITS-1:0] board_y;
    logic [MESH_X_BITS-1:0] board_x;
    logic [TILE_Y_BITS-1:0] tile_y;
    logic [TILE_X_BITS-1:0] tile_x;
    logic [LOCAL_BITS-1:0]  local_addr;
  } net_addr_t;

  localparam int NET_ADDR_BITS = $bits(net_addr_t);

  typedef struct packed {
    net_addr_t               dest;
    logic [PAYLOAD_BITS-1:0] payload;
    logic                    not_final_flit;
    logic                    is_idle_token;
  } flit_t;

  localparam int FLIT_BITS = $bits(flit_t);

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } fwd_state_t;

  // True when dest names this accelerator on this board and tile.
  function automatic logic is_self_addr(
    input net_addr_t              dest,
    input logic [MESH_X_BITS-1:0] board_x,
    input logic [MESH_Y_BITS-1:0] board_y,
    input logic [TILE_X_BITS-1:0] tile_x,
    input logic [TILE_Y_BITS-1:0] tile_y
  );
    return dest.acc && (dest.board_x == board_x) && (dest.board_y == board_y)
        && (dest.tile_x == tile_x) && (dest.tile_y == tile_y);
  endfunction

endpackage

// File: rtl/tinsel_acc_flit_fifo.sv
// Show-ahead flit FIFO, power-of-2 depth, state updated on the falling clock edge.
// Push and pop may coincide at any occupancy; reset is asynchronous active-high.
module tinsel_acc_flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; validity is carried by the pointers alone.
  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tinsel_acc_msg_forwarder.sv
// Message-aware forwarding accelerator: re-addresses every flit of a message to the
// destination held in its head payload. Statistics counters exist only with TINSEL_ACC_FWD_STATS_EN.
module tinsel_acc_msg_forwarder
  import tinsel_acc_pkg::*;
#(
  parameter int TILE_X    = 0,
  parameter int TILE_Y    = 0,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int DROP_SELF = 1,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MESH_X_BITS-1:0] board_x,
  input  logic [MESH_Y_BITS-1:0] board_y,
  input  logic [FLIT_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [FLIT_BITS-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef TINSEL_ACC_FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]       msg_count,
  output logic [CNT_W-1:0]       flit_count,
  output logic [CNT_W-1:0]       drop_count
`endif
);

  localparam logic [TILE_X_BITS-1:0] OWN_TILE_X = TILE_X_BITS'(TILE_X);
  localparam logic [TILE_Y_BITS-1:0] OWN_TILE_Y = TILE_Y_BITS'(TILE_Y);

  flit_t      in_head;
  flit_t      out_flit;
  net_addr_t  head_dest;
  net_addr_t  dest_q;
  net_addr_t  dest_nxt;
  fwd_state_t state;
  fwd_state_t state_nxt;
  logic       in_full, in_empty, out_full, out_empty;
  logic       in_push, out_pop;
  logic       head_is_self;
  logic       discard;
  logic       fire;

  // in_ready is held low for the whole time reset is asserted.
  assign in_ready  = !in_full && !rst_n;
  assign in_push   = in_valid && in_ready;
  assign out_valid = !out_empty;
  assign out_pop   = out_valid && out_ready;

  tinsel_acc_flit_fifo #(.DEPTH(IN_DEPTH), .WIDTH(FLIT_BITS)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .wdata (in_data),
    .pop   (fire),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty)
  );

  tinsel_acc_flit_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(FLIT_BITS)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire && !discard),
    .wdata (out_flit),
    .pop   (out_pop),
    .rdata (out_data),
    .full  (out_full),
    .empty (out_empty)
  );

  assign head_dest    = net_addr_t'(in_head.payload[NET_ADDR_BITS-1:0]);
  assign head_is_self = (DROP_SELF != 0)
                     && is_self_addr(head_dest, board_x, board_y, OWN_TILE_X, OWN_TILE_Y);

  // Discarded flits never need output space, so a DROP message drains under backpressure.
  assign fire = !in_empty && (discard || !out_full);

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    dest_nxt  = dest_q;
    discard   = 1'b0;
    out_flit  = in_head;
    unique case (state)
      ST_HEAD: begin
        if (!in_head.is_idle_token) begin
          dest_nxt = head_dest;
          if (head_is_self) begin
            discard   = 1'b1;
            state_nxt = in_head.not_final_flit ? ST_DROP : ST_HEAD;
          end else begin
            out_flit.dest          = head_dest;
            out_flit.is_idle_token = 1'b0;
            state_nxt = in_head.not_final_flit ? ST_BODY : ST_HEAD;
          end
        end
      end
      ST_BODY: begin
        if (!in_head.is_idle_token) begin
          out_flit.dest          = dest_q;
          out_flit.is_idle_token = 1'b0;
          if (!in_head.not_final_flit) state_nxt = ST_HEAD;
        end
      end
      ST_DROP: begin
        if (!in_head.is_idle_token) begin
          discard = 1'b1;
          if (!in_head.not_final_flit) state_nxt = ST_HEAD;
        end
      end
      default: state_nxt = ST_HEAD;
    endcase
  end

  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= ST_HEAD;
      dest_q <= '0;
    end else if (fire) begin
      state  <= state_nxt;
      dest_q <= dest_nxt;
    end
  end

`ifdef TINSEL_ACC_FWD_STATS_EN
  always_ff @(negedge clk or posedge rst_n) begin
    if (rst_n) begin
      msg_count  <= '0;
      flit_count <= '0;
      drop_count <= '0;
    end else if (fire && !in_head.is_idle_token) begin
      if (discard) begin
        if (!in_head.not_final_flit) drop_count <= drop_count + CNT_W'(1);
      end else begin
        flit_count <= flit_count + CNT_W'(1);
        if (!in_head.not_final_flit) msg_count <= msg_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_tinsel_acc_msg_forwarder.sv
// Self-checking bench for tinsel_acc_msg_forwarder: directed scenarios plus a randomized
// message stream, compared against a message-level reference model.
`timescale 1ns/1ps
module tb_tinsel_acc_msg_forwarder;
  import tinsel_acc_pkg::*;

  localparam int IN_DEPTH  = 4;
  localparam int OUT_DEPTH = 4;
  localparam int CNT_W     = 32;
  localparam logic [MESH_X_BITS-1:0] BX = 2'd1;
  localparam logic [MESH_Y_BITS-1:0] BY = 2'd2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  flit_t                in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [FLIT_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
`ifdef TINSEL_ACC_FWD_STATS_EN
  logic [CNT_W-1:0]     msg_count, flit_count, drop_count;
`endif

  tinsel_acc_msg_forwarder #(
    .TILE_X(0), .TILE_Y(0), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH),
    .DROP_SELF(1), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .board_x    (BX),
    .board_y    (BY),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef TINSEL_ACC_FWD_STATS_EN
    ,
    .msg_count  (msg_count),
    .flit_count (flit_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  flit_t send_q[$];
  flit_t exp_q[$];
  int    ready_mode = 1;
  int    gap_mode = 0;
  int    step_no = 0;
  int    n_out = 0;
  int    n_acc = 0;
  int    first_out_step = -1;
  int    last_out_step = -1;
  logic  last_out_valid, last_in_ready, last_acc;
  flit_t last_out;

  // Reference model state: message position and counters.
  logic      m_in_msg = 1'b0;
  logic      m_dropping = 1'b0;
  net_addr_t m_dest = '0;
  int        m_msgs = 0, m_flits = 0, m_drops = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_is_self(input net_addr_t d);
    return d.acc == 1'b1 && d.board_x == BX && d.board_y == BY && d.tile_x == 0 && d.tile_y == 0;
  endfunction

  function automatic net_addr_t self_dest();
    net_addr_t d;
    logic [31:0] r;
    r = $urandom;
    d = r[NET_ADDR_BITS-1:0];
    d.acc = 1'b1; d.board_x = BX; d.board_y = BY; d.tile_x = '0; d.tile_y = '0;
    return d;
  endfunction

  function automatic net_addr_t rand_dest();
    net_addr_t d;
    logic [31:0] r;
    r = $urandom;
    d = r[NET_ADDR_BITS-1:0];
    if (tb_is_self(d)) d.acc = 1'b0;
    return d;
  endfunction

  // The incoming dest field is random garbage: the forwarder must ignore it.
  function automatic flit_t mk_flit(input logic [31:0] payload, input logic nf, input logic idle);
    flit_t f;
    logic [31:0] r;
    r = $urandom;
    f.dest = r[NET_ADDR_BITS-1:0];
    f.payload = payload;
    f.not_final_flit = nf;
    f.is_idle_token = idle;
    return f;
  endfunction

  function automatic flit_t mk_head(input net_addr_t d, input logic nf);
    logic [31:0] p;
    p = $urandom;
    p[NET_ADDR_BITS-1:0] = d;
    return mk_flit(p, nf, 1'b0);
  endfunction

  function automatic void model_accept(input flit_t f);
    flit_t o;
    if (f.is_idle_token) begin
      exp_q.push_back(f);
      return;
    end
    if (!m_in_msg) begin
      m_dest = f.payload[NET_ADDR_BITS-1:0];
      m_dropping = tb_is_self(m_dest);
    end
    if (m_dropping) begin
      if (!f.not_final_flit) m_drops++;
    end else begin
      o.dest = m_dest;
      o.payload = f.payload;
      o.not_final_flit = f.not_final_flit;
      o.is_idle_token = 1'b0;
      exp_q.push_back(o);
      m_flits++;
      if (!f.not_final_flit) m_msgs++;
    end
    m_in_msg = f.not_final_flit;
  endfunction

  function automatic void model_reset();
    send_q.delete();
    exp_q.delete();
    m_in_msg = 1'b0; m_dropping = 1'b0; m_dest = '0;
    m_msgs = 0; m_flits = 0; m_drops = 0;
  endfunction

  // One cycle: drive on the rising edge, sample 1 ns later; the DUT acts on the falling edge.
  task automatic step();
    @(posedge clk);
    in_valid = (send_q.size() > 0) && (gap_mode == 0 || $urandom_range(1) == 1);
    if (in_valid) in_data = send_q[0];
    else          in_data = '0;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(3) != 0);
    endcase
    #1;
    step_no++;
    last_out_valid = out_valid;
    last_in_ready  = in_ready;
    last_acc       = 1'b0;
    if (out_valid && out_ready) begin
      last_out = out_data;
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else                   check("out_flit", out_data, exp_q.pop_front());
      n_out++;
      if (first_out_step < 0) first_out_step = step_no;
      last_out_step = step_no;
    end
    if (in_valid && in_ready) begin
      model_accept(send_q.pop_front());
      last_acc = 1'b1;
      n_acc++;
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 64'(send_q.size() + exp_q.size()), 64'd0);
    repeat (4) step();
    check({tag, "_quiet"}, out_valid, 1'b0);
  endtask

  initial begin
    net_addr_t d;
    int base;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #10;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1'b1);
`ifdef TINSEL_ACC_FWD_STATS_EN
    check("rst_msg_count", msg_count, '0);
    check("rst_drop_count", drop_count, '0);
`endif

    // T1: single-flit message, latency and re-addressing.
    ready_mode = 1;
    d = rand_dest();
    send_q.push_back(mk_head(d, 1'b0));
    step();
    check("t1_accepted", last_acc, 1'b1);
    step();
    check("t1_not_yet_valid", last_out_valid, 1'b0);
    step();
    check("t1_valid_2nd_edge", last_out_valid, 1'b1);
    check("t1_dest", last_out.dest, d);
    check("t1_not_final", last_out.not_final_flit, 1'b0);
    drain("t1", 20);

    // T2: three-flit message, all re-addressed, payloads preserved.
    base = n_out;
    d = rand_dest();
    send_q.push_back(mk_head(d, 1'b1));
    send_q.push_back(mk_flit(32'hAA, 1'b1, 1'b0));
    send_q.push_back(mk_flit(32'hBB, 1'b0, 1'b0));
    drain("t2", 40);
    check("t2_out_count", 64'(n_out - base), 64'd3);
    check("t2_last_payload", last_out.payload, 32'hBB);
    check("t2_last_dest", last_out.dest, d);

    // T3: self-addressed message dropped, next one forwarded.
    base = n_out;
    send_q.push_back(mk_head(self_dest(), 1'b1));
    send_q.push_back(mk_flit($urandom, 1'b0, 1'b0));
    d = rand_dest();
    send_q.push_back(mk_head(d, 1'b0));
    drain("t3", 40);
    check("t3_out_count", 64'(n_out - base), 64'd1);
    check("t3_dest", last_out.dest, d);
`ifdef TINSEL_ACC_FWD_STATS_EN
    check("t3_drop_count", drop_count, 32'd1);
`endif

    // T4: backpressure fills both FIFOs, then full-rate drain in order.
    ready_mode = 0;
    base = n_acc;
    for (int i = 0; i < 16; i++) send_q.push_back(mk_head(rand_dest(), 1'b0));
    repeat (20) step();
    check("t4_accepts_when_full", 64'(n_acc - base), 64'(IN_DEPTH + OUT_DEPTH));
    check("t4_in_ready_low", last_in_ready, 1'b0);
    ready_mode = 1;
    base = n_out;
    first_out_step = -1;
    drain("t4", 100);
    check("t4_out_count", 64'(n_out - base), 64'd16);
    check("t4_full_rate", 64'(last_out_step - first_out_step), 64'd15);

    // T5: idle token inside a message passes verbatim; later body keeps dest.
    base = n_out;
    d = rand_dest();
    send_q.push_back(mk_head(d, 1'b1));
    send_q.push_back(mk_flit(32'h11, 1'b1, 1'b0));
    send_q.push_back(mk_flit($urandom, 1'b0, 1'b1));
    send_q.push_back(mk_flit(32'h22, 1'b1, 1'b0));
    send_q.push_back(mk_flit(32'h33, 1'b0, 1'b0));
    drain("t5", 40);
    check("t5_out_count", 64'(n_out - base), 64'd5);
    check("t5_last_dest", last_out.dest, d);

    // T6: reset in the middle of a message.
    ready_mode = 0;
    send_q.push_back(mk_head(rand_dest(), 1'b1));
    send_q.push_back(mk_flit($urandom, 1'b1, 1'b0));
    repeat (5) step();
    check("t6_pending", last_out_valid, 1'b1);
    @(posedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_data", out_data, '0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    ready_mode = 1;
    base = n_out;
    d = rand_dest();
    send_q.push_back(mk_head(d, 1'b0));
    drain("t6", 40);
    check("t6_out_count", 64'(n_out - base), 64'd1);
    check("t6_dest", last_out.dest, d);

    // Randomized stream: mixed lengths, self messages, idle tokens, gaps and backpressure.
    ready_mode = 2;
    gap_mode = 1;
    for (int m = 0; m < 40; m++) begin
      int len;
      bit self_msg;
      len = $urandom_range(4, 1);
      self_msg = ($urandom_range(6) == 0);
      send_q.push_back(mk_head(self_msg ? self_dest() : rand_dest(), len > 1));
      for (int j = 1; j < len; j++) begin
        if (!self_msg && $urandom_range(4) == 0) send_q.push_back(mk_flit($urandom, 1'b0, 1'b1));
        send_q.push_back(mk_flit($urandom, j < len - 1, 1'b0));
      end
      if ($urandom_range(3) == 0) send_q.push_back(mk_flit($urandom, 1'b0, 1'b1));
    end
    drain("rand", 2000);
`ifdef TINSEL_ACC_FWD_STATS_EN
    check("stat_msg_count", msg_count, m_msgs);
    check("stat_flit_count", flit_count, m_flits);
    check("stat_drop_count", drop_count, m_drops);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
